ps_window_ctrl: RTL and testbench
=================================

# ps_window_ctrl

Controls the pixel-window stage that feeds the 3x3 convolution kernels. Accepts an 8-bit raster pixel stream, writes it round-robin into four internal line buffers, and once three complete lines are held, streams 3x3 pixel windows (72 bits) downstream under ready/valid flow control. A fourth buffer lets line N+3 be written while lines N..N+2 are read.

## Interface
- LINE_LENGTH, 640, pixels per line; also the depth of each line buffer
- i_clk  in  1  clock; all logic on rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_valid  in  1  input pixel strobe
- i_data  in  8  input pixel
- i_ready  in  1  downstream can accept a window this cycle
- o_valid  out  1  o_window holds a valid window
- o_window  out  72  [71:48] top (oldest) row, [47:24] middle, [23:0] bottom; within each row, leftmost pixel in MSBs
- o_busy  out  1  read FSM is in READ
- o_ovf  out  1  sticky overflow flag (only with PS_WINDOW_OVF_EN)

## Operation
- Write side: wcol (0..LINE_LENGTH-1) and wsel (0..3).
  - i_valid writes i_data to buffer wsel; wcol increments.
  - At wcol==LINE_LENGTH-1: wcol->0, wsel->wsel+1 mod 4, line completes.
- Fill count: nfill (0..4, 3 bits).
  - +1 on line completion, -1 on read-line completion, unchanged when both occur in the same cycle.
- Read FSM, states IDLE and READ:
  - IDLE->READ when nfill>=3.
  - In READ, a read strobe fires when i_ready=1. It pulses rd to buffers rsel, rsel+1, rsel+2 (mod 4), and rcol increments.
  - At rcol==LINE_LENGTH-1 with a strobe: rcol->0, rsel->rsel+1 mod 4, read-line completes, FSM -> IDLE.
  - IDLE re-evaluates nfill next cycle; there is always one idle cycle between lines.
- Row order: buffer rsel is the top row, rsel+2 the bottom.
- Each buffer returns three horizontally adjacent pixels starting at rcol. The last two columns replicate the right-edge pixel.
- Write with nfill==4: the line still completes. The data overwrites buffer wsel, which is the current top row, and nfill saturates at 4. Behaviour is otherwise undefined except as covered by PS_WINDOW_OVF_EN.
- o_busy = (state==READ).

## Timing
- Reset values: state IDLE; wcol, rcol, wsel, rsel, nfill = 0; o_valid = 0; o_window = 0; o_ovf = 0.
- Line-buffer internal pointers are reset by the same i_rstn.
- Read latency is 1 cycle: o_valid is the read strobe registered once, and o_window is the buffer output on the same cycle.
- i_ready low pauses reads. o_valid drops one cycle later. No window is skipped or repeated.
- o_valid is not gated by i_ready; downstream must sample whenever o_valid=1.
- Write and read may proceed in the same cycle on different buffers. The block never reads the buffer currently being written while nfill<4.
- Reset mid-line discards all buffered lines. The first window after reset requires 3 fresh lines.
- First window: o_valid rises 2 cycles after the cycle that writes the last pixel of line 3 (one cycle IDLE->READ, one cycle read latency), provided i_ready=1.

## Configuration
- PS_WINDOW_OVF_EN defined:
  - o_ovf port exists.
  - Set on a line completion while nfill==4; cleared only by reset.
  - The write that sets it is still performed (overwrites).
- Not defined: o_ovf port is absent and no overflow logic is synthesized.

## Structure
- Shared package ps_pkg:
  - KERNEL_ROWS=3, NUM_LINEBUF=4, PIX_W=8, WIN_W=72.
  - Read FSM state typedef.
- Four instances of the existing ps_linebuffer (8-bit write, 24-bit registered read).
- Natural sub-module: ps_window_fsm, holding the read FSM, rcol, rsel and the o_valid pipeline register.

## Test plan
- Reset, then stream 3 lines with line k pixel c = (k*16+c) mod 256, LINE_LENGTH=8, i_ready=1 -> first o_window = {00,01,02, 10,11,12, 20,21,22}. Window 7 = {07,07,07, 17,17,17, 27,27,27}. Exactly 8 windows.
- Toggle i_ready every other cycle during READ -> 8 windows, contiguous columns, no duplicates, o_valid pattern lags i_ready by 1.
- Stream 10 continuous lines -> wsel/rsel wrap 3->0. Window rows advance by one line each pass; top row of pass 2 = line 1.
- Complete a written line in the same cycle as a read-line completion -> nfill unchanged; the next READ starts after one IDLE cycle.
- Assert i_rstn low mid-READ at rcol=4 -> o_valid=0 and o_busy=0 immediately. No window until 3 new lines are written.
- With PS_WINDOW_OVF_EN, i_ready=0, write 5 lines -> o_ovf rises on completion of line 5 and stays high until reset. Without the macro, the port is absent and the build passes.

Source files
------------

// File: rtl/ps_pkg.sv
// ---------------------------------------------------------------------------
// ps_pkg
// Shared constants and types for the pixel-window stage.
//   KERNEL_ROWS / NUM_LINEBUF / PIX_W / WIN_W : window geometry
//   rd_state_e                                : read FSM state encoding
//   col_clamp()                               : right-edge column clamp
// ---------------------------------------------------------------------------
package ps_pkg;

  localparam int KERNEL_ROWS = 3;
  localparam int NUM_LINEBUF = 4;
  localparam int PIX_W       = 8;
  localparam int WIN_W       = 72;
  localparam int ROW_W       = KERNEL_ROWS * PIX_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  // Columns past the right edge fold back onto the last pixel of the line.
  function automatic int unsigned col_clamp(input int unsigned col,
                                            input int unsigned last);
    return (col > last) ? last : col;
  endfunction

endpackage

// File: rtl/ps_window_if.sv
// ---------------------------------------------------------------------------
// ps_window_if
// Pixel-in / window-out handshake bundle.
//   i_valid, i_data : raster pixel stream into the block
//   i_ready         : downstream can take a window this cycle
//   o_valid,o_window: 3x3 window out ([71:48] top row ... [23:0] bottom row)
// Modports: master = stream source / window sink, slave = ps_window_ctrl.
// ---------------------------------------------------------------------------
interface ps_window_if;
  import ps_pkg::*;

  logic              i_valid;
  logic [PIX_W-1:0]  i_data;
  logic              i_ready;
  logic              o_valid;
  logic [WIN_W-1:0]  o_window;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_valid, o_window
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_valid, o_window
  );

endinterface

// File: rtl/ps_linebuffer.sv
// ---------------------------------------------------------------------------
// ps_linebuffer
// One line of pixel storage. Writes land at an internal write pointer that
// walks 0..DEPTH-1 and wraps; reads return three horizontally adjacent
// pixels starting at i_raddr, registered, with the right edge replicated.
//   i_clk, i_rstn    : clock, async active-low reset (clears pointer/output)
//   i_we, i_wdata    : pixel write strobe and data
//   i_rd, i_raddr    : read strobe and starting column
//   o_rdata          : {pix[c], pix[c+1], pix[c+2]}, leftmost in MSBs
// ---------------------------------------------------------------------------
module ps_linebuffer
  import ps_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int COL_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [PIX_W-1:0]  i_wdata,
  input  logic              i_rd,
  input  logic [COL_W-1:0]  i_raddr,
  output logic [ROW_W-1:0]  o_rdata
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(DEPTH - 1);
  localparam int unsigned      LAST_U   = DEPTH - 1;

  logic [PIX_W-1:0] mem_r [DEPTH];
  logic [COL_W-1:0] wptr_r;
  logic [COL_W-1:0] addr1_s;
  logic [COL_W-1:0] addr2_s;

  // Write pointer: advances per written pixel, wraps at end of line.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_r <= {COL_W{1'b0}};
    end else if (i_we) begin
      if (wptr_r == LAST_COL) begin
        wptr_r <= {COL_W{1'b0}};
      end else begin
        wptr_r <= wptr_r + COL_W'(1);
      end
    end
  end

  // Pixel storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[wptr_r] <= i_wdata;
    end
  end

  // Neighbour addresses, clamped at the right edge.
  always_comb begin
    addr1_s = COL_W'(col_clamp(32'(i_raddr) + 32'd1, LAST_U));
    addr2_s = COL_W'(col_clamp(32'(i_raddr) + 32'd2, LAST_U));
  end

  // Registered three-pixel read; holds its value between strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rdata <= {ROW_W{1'b0}};
    end else if (i_rd) begin
      o_rdata <= {mem_r[i_raddr], mem_r[addr1_s], mem_r[addr2_s]};
    end
  end

endmodule

// File: rtl/ps_window_fsm.sv
// ---------------------------------------------------------------------------
// ps_window_fsm
// Read-side sequencer. Waits in IDLE for three filled lines, then sweeps one
// line of columns in READ, advancing one column per i_ready cycle. Always
// returns to IDLE for one cycle between lines.
//   i_clk, i_rstn   : clock, async active-low reset
//   i_ready         : downstream ready (acts as the read strobe in READ)
//   i_nfill         : number of complete lines held
//   o_rd            : read strobe this cycle (combinational)
//   o_rsel, o_rcol  : top-row buffer index and column being read
//   o_row_sel       : top-row buffer of the window now on the buffer outputs
//   o_rd_line_done  : last column of a line read this cycle
//   o_valid         : read strobe delayed one cycle
//   o_busy          : FSM in READ
// ---------------------------------------------------------------------------
module ps_window_fsm
  import ps_pkg::*;
#(
  parameter int LINE_LENGTH = 640,
  parameter int COL_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ready,
  input  logic [2:0]        i_nfill,
  output logic              o_rd,
  output logic [1:0]        o_rsel,
  output logic [COL_W-1:0]  o_rcol,
  output logic [1:0]        o_row_sel,
  output logic              o_rd_line_done,
  output logic              o_valid,
  output logic              o_busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LENGTH - 1);

  rd_state_e         state_r;
  logic [COL_W-1:0]  rcol_r;
  logic [1:0]        rsel_r;
  logic [1:0]        row_sel_r;
  logic              valid_r;
  logic              rd_s;

  // Read strobe and end-of-line detect.
  always_comb begin
    rd_s           = 1'b0;
    o_rd_line_done = 1'b0;
    if (state_r == ST_READ) begin
      rd_s           = i_ready;
      o_rd_line_done = i_ready && (rcol_r == LAST_COL);
    end else begin
      rd_s           = 1'b0;
      o_rd_line_done = 1'b0;
    end
  end

  // Read FSM, column/row pointers and output-valid pipeline.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r   <= ST_IDLE;
      rcol_r    <= {COL_W{1'b0}};
      rsel_r    <= 2'd0;
      row_sel_r <= 2'd0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= rd_s;
      case (state_r)
        ST_IDLE: begin
          if (i_nfill >= 3'(KERNEL_ROWS)) begin
            state_r <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_s) begin
            // Remember which buffers this strobe reads; rsel may advance now.
            row_sel_r <= rsel_r;
            if (rcol_r == LAST_COL) begin
              rcol_r  <= {COL_W{1'b0}};
              rsel_r  <= rsel_r + 2'd1;
              state_r <= ST_IDLE;
            end else begin
              rcol_r  <= rcol_r + COL_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rd      = rd_s;
  assign o_rsel    = rsel_r;
  assign o_rcol    = rcol_r;
  assign o_row_sel = row_sel_r;
  assign o_valid   = valid_r;
  assign o_busy    = (state_r == ST_READ);

endmodule

// File: rtl/ps_window_ctrl.sv
// ---------------------------------------------------------------------------
// ps_window_ctrl
// Pixel-window stage for the 3x3 convolution kernels. Writes the raster
// stream round-robin into four line buffers and, once three lines are held,
// streams 72-bit 3x3 windows under ready/valid flow control.
//   i_clk, i_rstn : clock, async active-low reset
//   win_if        : ps_window_if.slave (pixel in, window out)
//   o_busy        : read FSM in READ
//   o_ovf         : sticky overflow, only when PS_WINDOW_OVF_EN is defined
// Optional build macro: PS_WINDOW_OVF_EN.
// ---------------------------------------------------------------------------
module ps_window_ctrl
  import ps_pkg::*;
#(
  parameter int LINE_LENGTH = 640
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  ps_window_if.slave  win_if,
  output logic        o_busy
`ifdef PS_WINDOW_OVF_EN
  ,
  output logic        o_ovf
`endif
);

  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LENGTH - 1);

  logic [COL_W-1:0]  wcol_r;
  logic [1:0]        wsel_r;
  logic [2:0]        nfill_r;
  logic              line_done_s;
  logic              rd_s;
  logic              rd_line_done_s;
  logic [1:0]        rsel_s;
  logic [COL_W-1:0]  rcol_s;
  logic [1:0]        row_sel_s;
  logic [1:0]        row_mid_s;
  logic [1:0]        row_bot_s;
  logic              fsm_valid_s;
  logic [ROW_W-1:0]  rdata_s [NUM_LINEBUF];
  logic [NUM_LINEBUF-1:0] buf_we_s;
  logic [NUM_LINEBUF-1:0] buf_rd_s;

  // Last pixel of a line is being written this cycle.
  always_comb begin
    line_done_s = win_if.i_valid && (wcol_r == LAST_COL);
  end

  // Write column and buffer select.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wcol_r <= {COL_W{1'b0}};
      wsel_r <= 2'd0;
    end else if (win_if.i_valid) begin
      if (line_done_s) begin
        wcol_r <= {COL_W{1'b0}};
        wsel_r <= wsel_r + 2'd1;
      end else begin
        wcol_r <= wcol_r + COL_W'(1);
      end
    end
  end

  // Complete-line count; saturates at 4 when a write overruns the reader.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      nfill_r <= 3'd0;
    end else if (line_done_s && !rd_line_done_s) begin
      if (nfill_r != 3'(NUM_LINEBUF)) begin
        nfill_r <= nfill_r + 3'd1;
      end
    end else if (!line_done_s && rd_line_done_s) begin
      nfill_r <= nfill_r - 3'd1;
    end
  end

`ifdef PS_WINDOW_OVF_EN
  logic ovf_r;

  // Sticky overflow: a line completed while every buffer was already full.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf_r <= 1'b0;
    end else if (line_done_s && (nfill_r == 3'(NUM_LINEBUF))) begin
      ovf_r <= 1'b1;
    end
  end

  assign o_ovf = ovf_r;
`endif

  ps_window_fsm #(
    .LINE_LENGTH (LINE_LENGTH),
    .COL_W       (COL_W)
  ) u_fsm (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_ready        (win_if.i_ready),
    .i_nfill        (nfill_r),
    .o_rd           (rd_s),
    .o_rsel         (rsel_s),
    .o_rcol         (rcol_s),
    .o_row_sel      (row_sel_s),
    .o_rd_line_done (rd_line_done_s),
    .o_valid        (fsm_valid_s),
    .o_busy         (o_busy)
  );

  for (genvar g = 0; g < NUM_LINEBUF; g++) begin : g_lb
    // A buffer is read when it is one of the three rows starting at rsel.
    assign buf_we_s[g] = win_if.i_valid && (wsel_r == 2'(g));
    assign buf_rd_s[g] = rd_s && ((2'(g) - rsel_s) != 2'd3);

    ps_linebuffer #(
      .DEPTH (LINE_LENGTH),
      .COL_W (COL_W)
    ) u_lb (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_we    (buf_we_s[g]),
      .i_wdata (win_if.i_data),
      .i_rd    (buf_rd_s[g]),
      .i_raddr (rcol_s),
      .o_rdata (rdata_s[g])
    );
  end

  // Assemble the window from the registered buffer outputs, oldest row on top.
  always_comb begin
    row_mid_s       = row_sel_s + 2'd1;
    row_bot_s       = row_sel_s + 2'd2;
    win_if.o_window = {rdata_s[row_sel_s], rdata_s[row_mid_s], rdata_s[row_bot_s]};
  end

  assign win_if.o_valid = fsm_valid_s;

endmodule

// File: tb/tb_ps_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps_window_ctrl
// Directed bench for ps_window_ctrl with LINE_LENGTH = 8. Pixel c of line k
// is (k*16 + c) mod 256, so every expected window can be written by hand.
// ---------------------------------------------------------------------------
module tb_ps_window_ctrl;
  import ps_pkg::*;

  localparam int LL = 8;

  logic clk = 1'b0;
  logic rstn;
  logic busy;
`ifdef PS_WINDOW_OVF_EN
  logic ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [71:0] win_q [$];

  ps_window_if win_if ();

  ps_window_ctrl #(.LINE_LENGTH(LL)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .win_if (win_if),
    .o_busy (busy)
`ifdef PS_WINDOW_OVF_EN
    ,
    .o_ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Capture every window the DUT presents, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn && win_if.o_valid) win_q.push_back(win_if.o_window);
  end

  function automatic logic [7:0] pix(input int k, input int c);
    return 8'((k * 16 + c) % 256);
  endfunction

  function automatic logic [23:0] row(input int k, input int col);
    int c1, c2;
    c1 = (col + 1 > LL - 1) ? LL - 1 : col + 1;
    c2 = (col + 2 > LL - 1) ? LL - 1 : col + 2;
    return {pix(k, col), pix(k, c1), pix(k, c2)};
  endfunction

  function automatic logic [71:0] exp_win(input int top, input int col);
    return {row(top, col), row(top + 1, col), row(top + 2, col)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    win_if.i_valid = 1'b0;
    win_if.i_data  = 8'h00;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    win_q.delete();
  endtask

  task automatic write_line(input int k);
    for (int c = 0; c < LL; c++) begin
      win_if.i_valid = 1'b1;
      win_if.i_data  = pix(k, c);
      tick();
    end
    win_if.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    win_if.i_valid = 1'b0;
    win_if.i_data  = 8'h00;
    win_if.i_ready = 1'b1;
    tick();
    n_vec++;
    if (win_if.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", win_if.o_valid); end
    n_vec++;
    if (win_if.o_window !== 72'h0) begin n_err++; $display("FAIL reset_window got %h exp 0", win_if.o_window); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_first_window();
    apply_reset();
    win_if.i_ready = 1'b1;
    write_line(0); write_line(1); write_line(2);
    n_vec++;
    if (win_if.o_valid !== 1'b0) begin n_err++; $display("FAIL first_lat0_valid got %b exp 0", win_if.o_valid); end
    tick();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy got %b exp 1", busy); end
    n_vec++;
    if (win_if.o_valid !== 1'b0) begin n_err++; $display("FAIL first_lat1_valid got %b exp 0", win_if.o_valid); end
    tick();
    n_vec++;
    if (win_if.o_valid !== 1'b1) begin n_err++; $display("FAIL first_lat2_valid got %b exp 1", win_if.o_valid); end
    n_vec++;
    if (win_if.o_window !== 72'h000102_101112_202122) begin
      n_err++; $display("FAIL first_window got %h exp 000102101112202122", win_if.o_window);
    end
    repeat (12) tick();
    n_vec++;
    if (win_q.size() != 8) begin n_err++; $display("FAIL first_count got %0d exp 8", win_q.size()); end
    for (int i = 0; i < 8 && i < win_q.size(); i++) begin
      n_vec++;
      if (win_q[i] !== exp_win(0, i)) begin
        n_err++; $display("FAIL first_win%0d got %h exp %h", i, win_q[i], exp_win(0, i));
      end
    end
    if (win_q.size() >= 8) begin
      n_vec++;
      if (win_q[7] !== 72'h070707_171717_272727) begin
        n_err++; $display("FAIL first_edge_win7 got %h exp 070707171717272727", win_q[7]);
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL first_idle_after got %b exp 0", busy); end
  endtask

  task automatic test_ready_toggle();
    logic busy_before;
    apply_reset();
    win_if.i_ready = 1'b0;
    write_line(0); write_line(1); write_line(2);
    for (int cyc = 0; cyc < 40; cyc++) begin
      win_if.i_ready = (cyc % 2 == 0);
      busy_before = busy;
      tick();
      n_vec++;
      if (win_if.o_valid !== (busy_before & win_if.i_ready)) begin
        n_err++;
        $display("FAIL toggle_valid cyc %0d got %b exp %b", cyc, win_if.o_valid, busy_before & win_if.i_ready);
      end
    end
    win_if.i_ready = 1'b1;
    n_vec++;
    if (win_q.size() != 8) begin n_err++; $display("FAIL toggle_count got %0d exp 8", win_q.size()); end
    for (int i = 0; i < 8 && i < win_q.size(); i++) begin
      n_vec++;
      if (win_q[i] !== exp_win(0, i)) begin
        n_err++; $display("FAIL toggle_win%0d got %h exp %h", i, win_q[i], exp_win(0, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    win_if.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) write_line(k);
    repeat (30) tick();
    n_vec++;
    if (win_q.size() != 64) begin n_err++; $display("FAIL b2b_count got %0d exp 64", win_q.size()); end
    for (int i = 0; i < 64 && i < win_q.size(); i++) begin
      n_vec++;
      if (win_q[i] !== exp_win(i / 8, i % 8)) begin
        n_err++; $display("FAIL b2b_win%0d got %h exp %h", i, win_q[i], exp_win(i / 8, i % 8));
      end
    end
    if (win_q.size() > 8) begin
      n_vec++;
      if (win_q[8][71:48] !== 24'h101112) begin
        n_err++; $display("FAIL b2b_pass2_top got %h exp 101112", win_q[8][71:48]);
      end
    end
  endtask

  task automatic test_same_cycle_done();
    apply_reset();
    win_if.i_ready = 1'b1;
    write_line(0); write_line(1); write_line(2);
    tick();
    // Line 3 finishes on the same edge as the last read of pass 0.
    write_line(3);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL same_idle got %b exp 0", busy); end
    tick();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL same_busy got %b exp 1", busy); end
    n_vec++;
    if (win_if.o_valid !== 1'b0) begin n_err++; $display("FAIL same_gap_valid got %b exp 0", win_if.o_valid); end
    tick();
    n_vec++;
    if (win_if.o_valid !== 1'b1) begin n_err++; $display("FAIL same_valid got %b exp 1", win_if.o_valid); end
    n_vec++;
    if (win_if.o_window !== exp_win(1, 0)) begin
      n_err++; $display("FAIL same_window got %h exp %h", win_if.o_window, exp_win(1, 0));
    end
    repeat (30) tick();
    n_vec++;
    if (win_q.size() != 16) begin n_err++; $display("FAIL same_count got %0d exp 16", win_q.size()); end
    if (win_q.size() >= 16) begin
      n_vec++;
      if (win_q[15] !== exp_win(1, 7)) begin
        n_err++; $display("FAIL same_last got %h exp %h", win_q[15], exp_win(1, 7));
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL same_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    win_if.i_ready = 1'b1;
    write_line(0); write_line(1); write_line(2);
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    n_vec++;
    if (win_if.o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", win_if.o_valid); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
    tick();
    rstn = 1'b1;
    tick();
    win_q.delete();
    write_line(5); write_line(6);
    repeat (20) tick();
    n_vec++;
    if (win_q.size() != 0) begin n_err++; $display("FAIL midrst_nowin got %0d exp 0", win_q.size()); end
    write_line(7);
    repeat (3) tick();
    n_vec++;
    if (win_q.size() < 1) begin
      n_err++; $display("FAIL midrst_first_count got %0d exp >=1", win_q.size());
    end else if (win_q[0] !== exp_win(5, 0)) begin
      n_err++; $display("FAIL midrst_first got %h exp %h", win_q[0], exp_win(5, 0));
    end
  endtask

`ifdef PS_WINDOW_OVF_EN
  task automatic test_ovf();
    apply_reset();
    win_if.i_ready = 1'b0;
    for (int k = 0; k < 4; k++) write_line(k);
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_4lines got %b exp 0", ovf); end
    write_line(4);
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_5lines got %b exp 1", ovf); end
    repeat (5) tick();
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    rstn = 1'b0;
    #1;
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_reset got %b exp 0", ovf); end
    tick();
    rstn = 1'b1;
    win_if.i_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rstn = 1'b0;
    win_if.i_valid = 1'b0;
    win_if.i_data  = 8'h00;
    win_if.i_ready = 1'b0;
    test_reset();
    test_first_window();
    test_ready_toggle();
    test_back_to_back();
    test_same_cycle_done();
    test_reset_mid_read();
`ifdef PS_WINDOW_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
